// File: rtl/br_check_pkg.sv
// ---------------------------------------------------------------------------
// br_check_pkg : shared address/queue widths and branch-record type
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package br_check_pkg;

  localparam int InstAddrBus = 32;
  localparam int BrqDepth    = 4;
  localparam int BrqPtrW     = $clog2(BrqDepth);
  localparam int BrqCntW     = BrqPtrW + 1;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic                   br_p;
    logic [InstAddrBus-1:0] addr_p;
  } br_rec_t;

  function automatic logic [InstAddrBus-1:0] seq_pc(input logic [InstAddrBus-1:0] pc);
    return pc + InstAddrBus'(4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/br_fifo.sv
// ---------------------------------------------------------------------------
// br_fifo : circular queue of in-flight prediction records, clear has priority
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module br_fifo
  import br_check_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_clear,
  input  br_rec_t            i_wdata,
  output br_rec_t            o_head,
  output logic [BrqCntW-1:0] o_count,
  output logic               o_empty
);

  br_rec_t             r_mem [BrqDepth];
  logic [BrqPtrW-1:0]  r_rd_ptr;
  logic [BrqPtrW-1:0]  r_wr_ptr;
  logic [BrqCntW-1:0]  r_count;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == BrqCntW'(BrqDepth));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  // A pop frees the head slot first, so a full queue still accepts a push.
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + BrqPtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + BrqPtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + BrqCntW'(1);
        2'b01:   r_count <= r_count - BrqCntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear && !rst) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/br_check.sv
// ---------------------------------------------------------------------------
// br_check : compares retired branches against their predictions, flushes on mispredict
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module br_check
  import br_check_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [InstAddrBus-1:0] if_pc,
  input  logic                   if_br_p,
  input  logic [InstAddrBus-1:0] if_addr_p,
  input  logic                   ex_valid,
  input  logic                   ex_is_br,
  input  logic                   ex_jmp,
  input  logic [InstAddrBus-1:0] ex_target,
  output logic                   full,
  output logic                   flush,
  output logic [InstAddrBus-1:0] redirect_pc,
  output logic                   upd_is_br,
  output logic [InstAddrBus-1:0] upd_addr,
  output logic [InstAddrBus-1:0] upd_jmp_addr,
  output logic                   upd_jmp,
  output logic [31:0]            br_cnt,
  output logic [31:0]            mis_cnt,
  output logic                   err
);

  br_rec_t                w_head;
  br_rec_t                w_wdata;
  logic [BrqCntW-1:0]     w_count;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_mis;
  logic                   w_br_pop;
  logic [InstAddrBus-1:0] w_correct_pc;

  logic                   r_flush;
  logic [InstAddrBus-1:0] r_redirect_pc;
  logic                   r_upd_is_br;
  logic [InstAddrBus-1:0] r_upd_addr;
  logic [InstAddrBus-1:0] r_upd_jmp_addr;
  logic                   r_upd_jmp;
  logic [31:0]            r_br_cnt;
  logic [31:0]            r_mis_cnt;
  logic                   r_err;

  assign full     = (w_count == BrqCntW'(BrqDepth));
  assign w_pop    = ex_valid & ~w_empty;
  assign w_br_pop = w_pop & ex_is_br;

  // A non-branch popping a taken prediction means the predictor aliased onto it.
  assign w_mis = w_pop & (ex_is_br
                 ? ((w_head.br_p != ex_jmp) |
                    (w_head.br_p & ex_jmp & (w_head.addr_p != ex_target)))
                 : w_head.br_p);

  assign w_correct_pc = (ex_is_br & ex_jmp) ? ex_target : seq_pc(w_head.pc);
  assign w_push       = if_valid & (~full | w_pop) & ~w_mis;

  assign w_wdata.pc     = if_pc;
  assign w_wdata.br_p   = if_br_p;
  assign w_wdata.addr_p = if_addr_p;

  br_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_mis),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush        <= 1'b0;
      r_redirect_pc  <= '0;
      r_upd_is_br    <= 1'b0;
      r_upd_addr     <= '0;
      r_upd_jmp_addr <= '0;
      r_upd_jmp      <= 1'b0;
      r_br_cnt       <= '0;
      r_mis_cnt      <= '0;
      r_err          <= 1'b0;
    end else begin
      r_flush     <= w_mis;
      r_upd_is_br <= w_br_pop;
      if (w_mis) r_redirect_pc <= w_correct_pc;
      if (w_br_pop) begin
        r_upd_addr     <= w_head.pc;
        r_upd_jmp_addr <= ex_target;
        r_upd_jmp      <= ex_jmp;
        if (r_br_cnt != '1) r_br_cnt <= r_br_cnt + 32'd1;
      end
      if (w_mis && r_mis_cnt != '1) r_mis_cnt <= r_mis_cnt + 32'd1;
      if (ex_valid && w_empty) r_err <= 1'b1;
    end
  end

  assign flush        = r_flush;
  assign redirect_pc  = r_redirect_pc;
  assign upd_is_br    = r_upd_is_br;
  assign upd_addr     = r_upd_addr;
  assign upd_jmp_addr = r_upd_jmp_addr;
  assign upd_jmp      = r_upd_jmp;
  assign br_cnt       = r_br_cnt;
  assign mis_cnt      = r_mis_cnt;
  assign err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_br_check.sv
// ---------------------------------------------------------------------------
// tb_br_check : directed vectors and corner sequences for br_check
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_br_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_br_p, ex_valid, ex_is_br, ex_jmp;
  logic [31:0] if_pc, if_addr_p, ex_target;
  logic        full, flush, upd_is_br, upd_jmp, err;
  logic [31:0] redirect_pc, upd_addr, upd_jmp_addr, br_cnt, mis_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_br  = 0;
  int exp_mis = 0;

  br_check dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_br_p(if_br_p), .if_addr_p(if_addr_p),
    .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_jmp(ex_jmp), .ex_target(ex_target),
    .full(full), .flush(flush), .redirect_pc(redirect_pc),
    .upd_is_br(upd_is_br), .upd_addr(upd_addr), .upd_jmp_addr(upd_jmp_addr), .upd_jmp(upd_jmp),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        br_p;
    logic [31:0] addr_p;
    logic        is_br;
    logic        jmp;
    logic [31:0] target;
    logic        e_flush;
    logic [31:0] e_redir;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 1'b0; if_pc = '0; if_br_p = 1'b0; if_addr_p = '0;
    ex_valid = 1'b0; ex_is_br = 1'b0; ex_jmp = 1'b0; ex_target = '0;
  endtask

  task automatic push(input logic [31:0] pc, input logic bp, input logic [31:0] ap);
    if_valid = 1'b1; if_pc = pc; if_br_p = bp; if_addr_p = ap;
  endtask

  task automatic pop(input logic ib, input logic j, input logic [31:0] t);
    ex_valid = 1'b1; ex_is_br = ib; ex_jmp = j; ex_target = t;
  endtask

  function automatic logic [31:0] cnt();
    return 32'(dut.w_count);
  endfunction

  initial begin
    //           pc            br_p  addr_p        is_br jmp   target        flush redirect
    vecs[0] = '{32'h0000_0100, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0};
    vecs[1] = '{32'h0000_0100, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0180, 1'b1, 32'h0000_0180};
    vecs[2] = '{32'h0000_0104, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0108};
    vecs[3] = '{32'h0000_0200, 1'b1, 32'h0000_0400, 1'b1, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0500};
    vecs[4] = '{32'h0000_0300, 1'b1, 32'h0000_0400, 1'b1, 1'b0, 32'h0000_0400, 1'b1, 32'h0000_0304};
    vecs[5] = '{32'h0000_0310, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0999, 1'b0, 32'h0};
    vecs[6] = '{32'h0000_0320, 1'b0, 32'h0000_0555, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0};
    vecs[7] = '{32'hFFFF_FFFC, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000};

    idle();
    rst = 1'b1;
    step(); step();
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_upd_is_br", 32'(upd_is_br), 32'd0);
    chk("rst_upd_addr", upd_addr, 32'd0);
    chk("rst_br_cnt", br_cnt, 32'd0);
    chk("rst_mis_cnt", mis_cnt, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", cnt(), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      idle();
      push(vecs[i].pc, vecs[i].br_p, vecs[i].addr_p);
      step();
      idle();
      pop(vecs[i].is_br, vecs[i].jmp, vecs[i].target);
      step();
      idle();
      if (vecs[i].is_br) exp_br++;
      if (vecs[i].e_flush) exp_mis++;
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
      if (vecs[i].e_flush) chk($sformatf("v%0d_redirect", i), redirect_pc, vecs[i].e_redir);
      chk($sformatf("v%0d_upd_is_br", i), 32'(upd_is_br), 32'(vecs[i].is_br));
      if (vecs[i].is_br) begin
        chk($sformatf("v%0d_upd_addr", i), upd_addr, vecs[i].pc);
        chk($sformatf("v%0d_upd_jmp_addr", i), upd_jmp_addr, vecs[i].target);
        chk($sformatf("v%0d_upd_jmp", i), 32'(upd_jmp), 32'(vecs[i].jmp));
      end
      chk($sformatf("v%0d_br_cnt", i), br_cnt, 32'(exp_br));
      chk($sformatf("v%0d_mis_cnt", i), mis_cnt, 32'(exp_mis));
      chk($sformatf("v%0d_count", i), cnt(), 32'd0);
      step();
      chk($sformatf("v%0d_flush_gone", i), 32'(flush), 32'd0);
      chk($sformatf("v%0d_upd_gone", i), 32'(upd_is_br), 32'd0);
    end

    // Fill to full, drop an overflow push, then pop+push while full.
    for (int i = 0; i < 4; i++) begin
      idle();
      push(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
      step();
    end
    idle();
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", cnt(), 32'd4);
    push(32'hDEAD_0000, 1'b0, 32'h0);
    step();
    idle();
    chk("overflow_count", cnt(), 32'd4);
    push(32'h2000, 1'b0, 32'h0);
    pop(1'b1, 1'b0, 32'h0);
    step();
    idle();
    exp_br++;
    chk("pp_count", cnt(), 32'd4);
    chk("pp_full", 32'(full), 32'd1);
    chk("pp_upd_addr", upd_addr, 32'h1000);
    chk("pp_flush", 32'(flush), 32'd0);
    begin
      logic [31:0] order [4];
      order[0] = 32'h1004; order[1] = 32'h1008; order[2] = 32'h100C; order[3] = 32'h2000;
      for (int i = 0; i < 4; i++) begin
        pop(1'b1, 1'b0, 32'h0);
        step();
        idle();
        exp_br++;
        chk($sformatf("drain%0d_upd_addr", i), upd_addr, order[i]);
      end
    end
    chk("drain_count", cnt(), 32'd0);
    chk("drain_full", 32'(full), 32'd0);
    chk("drain_br_cnt", br_cnt, 32'(exp_br));
    chk("drain_mis_cnt", mis_cnt, 32'(exp_mis));

    // Mispredict with a same-cycle push: the push must be discarded.
    push(32'h400, 1'b0, 32'h0);
    step();
    idle();
    pop(1'b1, 1'b1, 32'h440);
    push(32'h404, 1'b0, 32'h0);
    step();
    idle();
    exp_br++; exp_mis++;
    chk("mp_flush", 32'(flush), 32'd1);
    chk("mp_redirect", redirect_pc, 32'h440);
    chk("mp_count", cnt(), 32'd0);
    chk("mp_mis_cnt", mis_cnt, 32'(exp_mis));
    step();
    chk("mp_flush_gone", 32'(flush), 32'd0);
    chk("mp_count_after", cnt(), 32'd0);

    // Retire on empty queue: sticky error, no side effects.
    pop(1'b1, 1'b1, 32'h777);
    step();
    idle();
    chk("err_set", 32'(err), 32'd1);
    chk("err_no_flush", 32'(flush), 32'd0);
    chk("err_no_upd", 32'(upd_is_br), 32'd0);
    chk("err_br_cnt", br_cnt, 32'(exp_br));
    chk("err_mis_cnt", mis_cnt, 32'(exp_mis));
    step();
    chk("err_sticky", 32'(err), 32'd1);

    // Reset mid-stream overrides same-cycle push/pop.
    push(32'h500, 1'b1, 32'h900);
    step();
    chk("mid_count_pre", cnt(), 32'd1);
    rst = 1'b1;
    push(32'h504, 1'b0, 32'h0);
    pop(1'b0, 1'b0, 32'h0);
    step();
    idle();
    chk("mid_rst_count", cnt(), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_flush", 32'(flush), 32'd0);
    chk("mid_rst_redirect", redirect_pc, 32'd0);
    chk("mid_rst_br_cnt", br_cnt, 32'd0);
    chk("mid_rst_mis_cnt", mis_cnt, 32'd0);
    chk("mid_rst_upd_addr", upd_addr, 32'd0);
    rst = 1'b0;
    push(32'h600, 1'b0, 32'h0);
    step();
    idle();
    chk("post_rst_push", cnt(), 32'd1);
    chk("post_rst_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
